// File: rtl/clock_ratio_meter_if.sv
// Monitor bundle for clock_ratio_meter: measurement controls in, results out.
// master: drives i_meas_en/i_meas_clk, sees results. slave: the meter.
interface clock_ratio_meter_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 i_meas_en;
    logic                 i_meas_clk;
    logic [CNT_WIDTH-1:0] o_period;
    logic [CNT_WIDTH-1:0] o_high_time;
    logic                 o_valid;
    logic                 o_locked;
    logic                 o_overflow;

    modport master (
        output i_meas_en,
        output i_meas_clk,
        input  o_period,
        input  o_high_time,
        input  o_valid,
        input  o_locked,
        input  o_overflow
    );

    modport slave (
        input  i_meas_en,
        input  i_meas_clk,
        output o_period,
        output o_high_time,
        output o_valid,
        output o_locked,
        output o_overflow
    );
endinterface

// File: rtl/clock_ratio_meter.sv
// Measures period and high time of a slow asynchronous clock in ref cycles.
// Ports: i_ref_clk, i_rst_n (async low), bus (slave: en/clk in, results out).
module clock_ratio_meter #(
    parameter int CNT_WIDTH   = 8,
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                i_ref_clk,
    input logic                i_rst_n,
    clock_ratio_meter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        LOCKED
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [3:0]           LOCK_MATCH = 4'(LOCK_COUNT);

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_level;
    logic                   rise;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] hcnt_q;
    logic [CNT_WIDTH-1:0] hcnt_d;
    logic [CNT_WIDTH-1:0] period_q;
    logic [CNT_WIDTH-1:0] high_q;

    logic [3:0] match_q;
    logic [3:0] match_d;
    logic [3:0] match_hit;
    logic       same_period;

    logic valid_q;
    logic locked_q;
    logic locked_d;
    logic ovf_q;
    logic ovf_d;
    logic capture;
    logic count_en;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign rise       = sync_level & ~hist_q;

    // match_q==0 marks the first capture after ARM, which never matches.
    assign same_period = (match_q != 4'd0) && (cnt_q == period_q);

    always_comb begin
        match_hit = 4'd1;
        if (same_period) begin
            if (match_q >= LOCK_MATCH) begin
                match_hit = LOCK_MATCH;
            end else begin
                match_hit = match_q + 4'd1;
            end
        end
    end

    // Counters restart at 1 on a rise so the rise cycle itself is counted.
    always_comb begin
        cnt_d  = '0;
        hcnt_d = '0;
        if (count_en) begin
            if (rise) begin
                cnt_d  = CNT_ONE;
                hcnt_d = CNT_ONE;
            end else begin
                cnt_d  = cnt_q;
                hcnt_d = hcnt_q;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (sync_level && (hcnt_q != CNT_MAX)) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        locked_d = locked_q;
        ovf_d    = ovf_q;
        capture  = 1'b0;
        count_en = 1'b0;
        if (!bus.i_meas_en) begin
            state_d  = IDLE;
            match_d  = '0;
            locked_d = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = ARM;
                    match_d  = '0;
                    locked_d = 1'b0;
                    ovf_d    = 1'b0;
                end
                ARM: begin
                    count_en = 1'b1;
                    if (rise) begin
                        state_d = MEASURE;
                        match_d = '0;
                    end
                end
                MEASURE, LOCKED: begin
                    count_en = 1'b1;
                    // A rise on the saturated count still captures.
                    if (rise) begin
                        capture = 1'b1;
                        match_d = match_hit;
                        if (match_hit == LOCK_MATCH) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            state_d  = MEASURE;
                            locked_d = 1'b0;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_d  = ARM;
                        match_d  = '0;
                        locked_d = 1'b0;
                        ovf_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            match_q  <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.i_meas_clk};
            hist_q   <= sync_level;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            match_q  <= match_d;
            valid_q  <= capture;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
            if (capture) begin
                period_q <= cnt_q;
                high_q   <= hcnt_q;
            end
        end
    end

    assign bus.o_period    = period_q;
    assign bus.o_high_time = high_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_locked    = locked_q;
    assign bus.o_overflow  = ovf_q;
endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed testbench for clock_ratio_meter.
// Drives a programmable divided clock and checks captures, lock, overflow.
module tb_clock_ratio_meter;
    localparam int CW = 8;

    logic ref_clk;
    logic ref_dly;
    logic rst_n;
    logic meas_en;
    logic gen_clk;
    logic ratio1;

    int errors;
    int checks;
    int per;
    int hi;
    int ph;
    int new_per;
    int new_hi;
    int gen_rises;

    clock_ratio_meter_if #(.CNT_WIDTH(CW)) bus ();

    assign bus.i_meas_en  = meas_en;
    assign bus.i_meas_clk = ratio1 ? ref_dly : gen_clk;

    clock_ratio_meter #(
        .CNT_WIDTH  (CW),
        .LOCK_COUNT (4),
        .SYNC_STAGES(2)
    ) dut (
        .i_ref_clk(ref_clk),
        .i_rst_n  (rst_n),
        .bus      (bus)
    );

    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    // Same frequency as ref_clk, skewed 1ns so posedge sampling sees 0.
    initial begin
        ref_dly = 1'b0;
        #1;
        forever #5 ref_dly = ~ref_dly;
    end

    // Divided clock: new period/high take effect only at a period boundary.
    initial begin
        per       = 4;
        hi        = 2;
        ph        = 0;
        new_per   = 4;
        new_hi    = 2;
        gen_clk   = 1'b0;
        gen_rises = 0;
        forever begin
            @(negedge ref_clk);
            if (ph + 1 >= per) begin
                ph  = 0;
                per = new_per;
                hi  = new_hi;
            end else begin
                ph = ph + 1;
            end
            if ((per != 0) && (ph < hi) && !gen_clk) begin
                gen_rises = gen_rises + 1;
            end
            gen_clk = (per != 0) && (ph < hi);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget,
                              output int waited);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && (n < budget)) begin
            @(negedge ref_clk);
            n   = n + 1;
            got = bus.o_valid;
        end
        waited = n;
        check(tag, 32'(got), 32'd1);
    endtask

    initial begin
        int w;
        int k;
        int cyc;
        int vcount;
        int lock_seen;
        int base;
        int guard;

        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        meas_en = 1'b1;
        ratio1  = 1'b0;

        // 1: reset with enable high and clock toggling
        repeat (6) @(negedge ref_clk);
        check("rst_period", 32'(bus.o_period), 32'd0);
        check("rst_high", 32'(bus.o_high_time), 32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_locked", 32'(bus.o_locked), 32'd0);
        check("rst_ovf", 32'(bus.o_overflow), 32'd0);
        rst_n  = 1'b1;
        vcount = 0;
        repeat (4) begin
            @(negedge ref_clk);
            if (bus.o_valid) vcount = vcount + 1;
        end
        check("arm_no_early_valid", 32'(vcount), 32'd0);

        // bounce through IDLE so ARM starts on a genuine edge
        meas_en = 1'b0;
        repeat (3) @(negedge ref_clk);
        meas_en = 1'b1;

        // 2: divide by 4, 2 high
        for (int i = 0; i < 4; i++) begin
            wait_valid("t2_valid", 40, w);
            check("t2_period", 32'(bus.o_period), 32'd4);
            check("t2_high", 32'(bus.o_high_time), 32'd2);
            if (i > 0) check("t2_gap", 32'(w), 32'd4);
            check("t2_locked", 32'(bus.o_locked), 32'(i == 3));
        end
        check("t2_ovf", 32'(bus.o_overflow), 32'd0);

        // 3: switch to period 10, high 4 while locked
        new_per = 10;
        new_hi  = 4;
        k       = 0;
        do begin
            wait_valid("t3_valid", 40, w);
            k = k + 1;
        end while ((bus.o_period == 8'd4) && (k < 6));
        check("t3_mis_period", 32'(bus.o_period), 32'd10);
        check("t3_mis_high", 32'(bus.o_high_time), 32'd4);
        check("t3_mis_locked", 32'(bus.o_locked), 32'd0);
        for (int i = 0; i < 3; i++) begin
            wait_valid("t3_valid", 40, w);
            check("t3_period", 32'(bus.o_period), 32'd10);
            check("t3_high", 32'(bus.o_high_time), 32'd4);
            check("t3_locked", 32'(bus.o_locked), 32'(i == 2));
        end

        // 4: hold low -> overflow 255 cycles after last counter reset
        new_per = 0;
        new_hi  = 0;
        cyc     = 0;
        k       = 0;
        while (!bus.o_overflow && (k < 600)) begin
            @(negedge ref_clk);
            k = k + 1;
            if (bus.o_valid) cyc = 0;
            else cyc = cyc + 1;
        end
        check("t4_ovf", 32'(bus.o_overflow), 32'd1);
        check("t4_ovf_delay", 32'(cyc), 32'd255);
        check("t4_ovf_locked", 32'(bus.o_locked), 32'd0);
        check("t4_ovf_valid", 32'(bus.o_valid), 32'd0);
        new_per = 2;
        new_hi  = 1;
        for (int i = 0; i < 4; i++) begin
            wait_valid("t4_valid", 40, w);
            check("t4_period", 32'(bus.o_period), 32'd2);
            check("t4_high", 32'(bus.o_high_time), 32'd1);
            check("t4_locked", 32'(bus.o_locked), 32'(i == 3));
        end
        check("t4_ovf_sticky", 32'(bus.o_overflow), 32'd1);

        // 5: lock at period 15, drop enable mid-period
        new_per = 15;
        new_hi  = 7;
        k       = 0;
        do begin
            wait_valid("t5_valid", 40, w);
            k = k + 1;
        end while ((bus.o_period == 8'd2) && (k < 8));
        check("t5_mis_period", 32'(bus.o_period), 32'd15);
        check("t5_mis_locked", 32'(bus.o_locked), 32'd0);
        for (int i = 0; i < 3; i++) begin
            wait_valid("t5_valid", 40, w);
            check("t5_period", 32'(bus.o_period), 32'd15);
            check("t5_high", 32'(bus.o_high_time), 32'd7);
            check("t5_locked", 32'(bus.o_locked), 32'(i == 2));
        end
        repeat (5) @(negedge ref_clk);
        meas_en = 1'b0;
        @(negedge ref_clk);
        check("t5_off_locked", 32'(bus.o_locked), 32'd0);
        check("t5_off_ovf", 32'(bus.o_overflow), 32'd0);
        check("t5_off_period", 32'(bus.o_period), 32'd15);
        check("t5_off_valid", 32'(bus.o_valid), 32'd0);
        guard = 0;
        while (!gen_clk && (guard < 40)) begin
            @(negedge ref_clk);
            guard = guard + 1;
        end
        while (gen_clk && (guard < 80)) begin
            @(negedge ref_clk);
            guard = guard + 1;
        end
        base    = gen_rises;
        meas_en = 1'b1;
        wait_valid("t5_re_valid", 80, w);
        check("t5_two_rises", 32'((gen_rises - base) >= 2), 32'd1);
        check("t5_re_period", 32'(bus.o_period), 32'd15);
        check("t5_re_high", 32'(bus.o_high_time), 32'd7);

        // 6a: async reset mid-measurement while locked
        for (int i = 0; i < 3; i++) begin
            wait_valid("t6_valid", 40, w);
            check("t6_locked", 32'(bus.o_locked), 32'(i == 2));
        end
        repeat (4) @(negedge ref_clk);
        @(posedge ref_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_period", 32'(bus.o_period), 32'd0);
        check("t6_rst_high", 32'(bus.o_high_time), 32'd0);
        check("t6_rst_locked", 32'(bus.o_locked), 32'd0);
        check("t6_rst_valid", 32'(bus.o_valid), 32'd0);
        @(negedge ref_clk);
        rst_n = 1'b1;

        // 6b: measured clock equal to ref clock
        wait_valid("t6_meas_valid", 100, w);
        ratio1    = 1'b1;
        lock_seen = 0;
        k         = 0;
        while (!bus.o_overflow && (k < 600)) begin
            @(negedge ref_clk);
            k = k + 1;
            if (bus.o_locked) lock_seen = lock_seen + 1;
        end
        check("t6_ratio1_ovf", 32'(bus.o_overflow), 32'd1);
        repeat (300) begin
            @(negedge ref_clk);
            if (bus.o_locked) lock_seen = lock_seen + 1;
        end
        check("t6_ratio1_nolock", 32'(lock_seen), 32'd0);
        check("t6_ratio1_sticky", 32'(bus.o_overflow), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clock_ratio_meter.md
Name: clock_ratio_meter

Overview:
Measures a clock produced by clock_divider (or any slower clock) in units of the reference clock. It reports the measured period and high time, and asserts lock once the ratio is stable. It sits next to the divider as an on-chip ratio checker and self-test monitor. The measured clock is treated as asynchronous and is sampled through a synchronizer.

Parameters:
CNT_WIDTH, 8, width of the period and high-time counters and outputs.
LOCK_COUNT, 4, number of consecutive identical period captures required to assert lock (range 2..15).
SYNC_STAGES, 2, number of synchronizer flops on i_meas_clk (minimum 2).

Ports:
i_ref_clk  input  1  reference clock; all logic runs on its rising edge
i_rst_n  input  1  asynchronous active-low reset
i_meas_en  input  1  measurement enable; low forces IDLE
i_meas_clk  input  1  clock under measurement, sampled as data
o_period  output  CNT_WIDTH  last captured period, in ref cycles
o_high_time  output  CNT_WIDTH  last captured high time, in ref cycles
o_valid  output  1  one-cycle pulse when o_period/o_high_time update
o_locked  output  1  ratio stable
o_overflow  output  1  sticky: no rising edge within 2^CNT_WIDTH-1 cycles

Behaviour:
- Reset (async, i_rst_n=0):
  - all outputs 0; synchronizer, edge register, counters and match counter 0; state IDLE.
- Synchronizer and edge detect:
  - SYNC_STAGES flops, then one history flop.
  - rise = sync_level & ~history.
  - Detection latency is fixed at SYNC_STAGES+1 ref cycles. Measurement is unaffected because both edges see the same latency.
- Counters (active in ARM, MEASURE, LOCKED):
  - on rise: cnt <= 1, hcnt <= 1.
  - otherwise: cnt <= cnt+1, saturating at 2^CNT_WIDTH-1; hcnt <= hcnt + sync_level, saturating.
  - A divide-by-N clock therefore yields period N.
- States:
  - IDLE:
    - counters 0, o_valid 0, o_locked 0, o_overflow cleared.
    - o_period/o_high_time hold their last values.
    - i_meas_en=1 -> ARM.
  - ARM:
    - waits for the first rise, which starts counting -> MEASURE with match=0.
    - No capture occurs in ARM.
  - MEASURE:
    - on rise: o_period<=cnt, o_high_time<=hcnt, o_valid=1 next cycle.
    - if the new period equals the previous capture, match++; otherwise match<=1. The first capture after ARM sets match=1.
    - match reaching LOCK_COUNT -> LOCKED, with o_locked=1 in the same cycle as that o_valid.
  - LOCKED:
    - capture as in MEASURE.
    - mismatched period -> MEASURE, match=1; o_locked drops in the same cycle its o_valid rises.
- Overflow:
  - in MEASURE/LOCKED, cnt reaching 2^CNT_WIDTH-1 with no rise -> o_overflow=1 (sticky), o_locked=0, state ARM, no o_valid.
  - o_overflow clears only in IDLE or on reset.
- i_meas_en deasserted in any state:
  - next cycle -> IDLE; o_valid and o_locked 0.
  - any in-flight period is discarded.
- Simultaneous rise and saturation: rise wins, and capture uses the saturated value.
- Rise coincident with i_meas_en falling: discarded.
- A measured clock equal to i_ref_clk (divider ratio 1), or held static (divider disabled or ratio 0), samples constant and ends in overflow.
- Minimum measurable period is 2 (high 1).

Test Plan:
1. Reset with i_meas_en=1 and i_meas_clk toggling -> all outputs 0 during reset. After release: ARM, then MEASURE, with no o_valid before the second detected rise.
2. Divider ratio 4 (2 high/2 low) -> every o_valid shows o_period=4, o_high_time=2, pulses 4 ref cycles apart. o_locked=1 with the 4th capture.
3. While locked, switch to bench clock period 10, high 4 -> first mismatched capture drops o_locked. Relock after 4 captures of o_period=10, o_high_time=4.
4. Hold i_meas_clk low -> 255 ref cycles after the last counter reset, o_overflow=1, o_locked=0, no o_valid. Restart a period-2 clock -> relocks with period 2, high 1, while o_overflow stays 1.
5. Drop i_meas_en mid-period while locked at period 15 -> next cycle o_locked=0, o_overflow=0, o_period holds 15. Re-enable -> first o_valid arrives only after two fresh rises.
6. Assert i_rst_n=0 asynchronously mid-measurement -> outputs 0 immediately, before the next i_ref_clk edge. Separately, divider ratio 1 (measured clock = ref clock) -> o_overflow=1, o_locked never asserts.
